// File: rtl/gtp_frame_gen_param.sv
// Transmit-side frame generator for GTP bring-up / BER tests: K28.5 alignment burst,
// then repeating frames of table / counter / PRBS7 data words closed by a comma word.
module gtp_frame_gen_param #(
   parameter int unsigned BYTES       = 2,
   parameter int unsigned ALIGN_WORDS = 16,
   parameter int unsigned FRAME_WORDS = 6
) (
   input  logic                 tx_clk,
   input  logic                 reset_n,
   input  logic                 ready,
   input  logic [1:0]           mode,
   output logic [8*BYTES-1:0]   tx_data,
   output logic [BYTES-1:0]     tx_charisk,
   output logic                 frame_start,
   output logic [15:0]          frame_cnt
);

   localparam int unsigned DATA_W    = 8 * BYTES;
   localparam int unsigned MAX_WORDS = (ALIGN_WORDS > FRAME_WORDS) ? ALIGN_WORDS : FRAME_WORDS;
   localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1);
   localparam logic [DATA_W-1:0] COMMA_WORD = {BYTES{8'hBC}};

   typedef enum logic [1:0] {IDLE, ALIGN, DATA, COMMA} state_t;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     word_cnt, word_cnt_nxt;
   logic [1:0]           mode_q, mode_nxt;
   logic [2:0]           tab_idx, tab_idx_nxt;
   logic [7:0]           byte_cnt, byte_cnt_nxt;
   logic [6:0]           prbs, prbs_nxt;
   logic [DATA_W-1:0]    tx_data_nxt;
   logic [BYTES-1:0]     tx_charisk_nxt;
   logic                 frame_start_nxt;
   logic [15:0]          frame_cnt_nxt;

   logic                 entering;
   logic [1:0]           gen_mode;
   logic [2:0]           g_idx;
   logic [7:0]           g_cnt;
   logic [6:0]           g_prbs;
   logic                 nb;
   logic [7:0]           pbyte;
   logic [DATA_W-1:0]    tab_w, cnt_w, prbs_w, gen_word;

   function automatic logic [7:0] tab_byte(input logic [2:0] i);
      case (i)
         3'd0:    tab_byte = 8'h54;
         3'd1:    tab_byte = 8'h58;
         3'd2:    tab_byte = 8'h34;
         3'd3:    tab_byte = 8'h40;
         3'd4:    tab_byte = 8'hA7;
         3'd5:    tab_byte = 8'h23;
         default: tab_byte = 8'h54;
      endcase
   endfunction

   // First data word of a frame: after the alignment burst or after the frame's comma.
   assign entering = ready && (((state == ALIGN) && (word_cnt == CNT_W'(ALIGN_WORDS)))
                               || (state == COMMA));
   assign gen_mode = entering ? ((mode == 2'd3) ? 2'd0 : mode) : mode_q;

   // One word of every generator; frame-local state restarts on frame entry.
   always_comb begin : data_gen
      g_idx  = entering ? 3'd0  : tab_idx;
      g_cnt  = entering ? 8'd0  : byte_cnt;
      g_prbs = entering ? 7'h7F : prbs;
      nb     = 1'b0;
      pbyte  = '0;
      tab_w  = '0;
      cnt_w  = '0;
      prbs_w = '0;
      for (int k = 0; k < BYTES; k++) begin
         tab_w = {tab_byte(g_idx), tab_w[DATA_W-1:8]};
         g_idx = (g_idx == 3'd5) ? 3'd0 : g_idx + 3'd1;
         cnt_w = {g_cnt, cnt_w[DATA_W-1:8]};
         g_cnt = g_cnt + 8'd1;
         // first PRBS bit of the byte ends up in bit 0
         for (int b = 0; b < 8; b++) begin
            nb     = g_prbs[6] ^ g_prbs[5];
            g_prbs = {g_prbs[5:0], nb};
            pbyte  = {nb, pbyte[7:1]};
         end
         prbs_w = {pbyte, prbs_w[DATA_W-1:8]};
      end
      case (gen_mode)
         2'd1:    gen_word = cnt_w;
         2'd2:    gen_word = prbs_w;
         default: gen_word = tab_w;
      endcase
   end

   always_ff @(posedge tx_clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         word_cnt    <= '0;
         mode_q      <= 2'd0;
         tab_idx     <= 3'd0;
         byte_cnt    <= 8'd0;
         prbs        <= 7'h7F;
         tx_data     <= '0;
         tx_charisk  <= '0;
         frame_start <= 1'b0;
         frame_cnt   <= 16'd0;
      end else begin
         state       <= state_nxt;
         word_cnt    <= word_cnt_nxt;
         mode_q      <= mode_nxt;
         tab_idx     <= tab_idx_nxt;
         byte_cnt    <= byte_cnt_nxt;
         prbs        <= prbs_nxt;
         tx_data     <= tx_data_nxt;
         tx_charisk  <= tx_charisk_nxt;
         frame_start <= frame_start_nxt;
         frame_cnt   <= frame_cnt_nxt;
      end
   end

   // Next state and the word presented with it.
   always_comb begin : fsm_next
      state_nxt       = state;
      word_cnt_nxt    = word_cnt;
      mode_nxt        = mode_q;
      tab_idx_nxt     = tab_idx;
      byte_cnt_nxt    = byte_cnt;
      prbs_nxt        = prbs;
      tx_data_nxt     = '0;
      tx_charisk_nxt  = '0;
      frame_start_nxt = 1'b0;
      frame_cnt_nxt   = frame_cnt;
      if (!ready) begin
         state_nxt = IDLE;
      end else if (entering) begin
         state_nxt       = DATA;
         word_cnt_nxt    = CNT_W'(1);
         mode_nxt        = gen_mode;
         tab_idx_nxt     = g_idx;
         byte_cnt_nxt    = g_cnt;
         prbs_nxt        = g_prbs;
         tx_data_nxt     = gen_word;
         frame_start_nxt = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               state_nxt      = ALIGN;
               word_cnt_nxt   = CNT_W'(1);
               tx_data_nxt    = COMMA_WORD;
               tx_charisk_nxt = '1;
            end
            ALIGN: begin
               word_cnt_nxt   = word_cnt + CNT_W'(1);
               tx_data_nxt    = COMMA_WORD;
               tx_charisk_nxt = '1;
            end
            DATA: begin
               if (word_cnt == CNT_W'(FRAME_WORDS)) begin
                  state_nxt      = COMMA;
                  tx_data_nxt    = COMMA_WORD;
                  tx_charisk_nxt = '1;
                  frame_cnt_nxt  = frame_cnt + 16'd1;
               end else begin
                  word_cnt_nxt = word_cnt + CNT_W'(1);
                  tab_idx_nxt  = g_idx;
                  byte_cnt_nxt = g_cnt;
                  prbs_nxt     = g_prbs;
                  tx_data_nxt  = gen_word;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gtp_frame_gen_param.sv
// Scoreboard bench for gtp_frame_gen_param: stimulus pushes expected words from a
// byte-stream reference model; a monitor pops and compares every cycle.
module tb_gtp_frame_gen_param;

   localparam int unsigned BYTES       = 4;
   localparam int unsigned ALIGN_WORDS = 4;
   localparam int unsigned FRAME_WORDS = 70;
   localparam int unsigned DW          = 8 * BYTES;
   localparam int unsigned NBITS       = FRAME_WORDS * BYTES * 8;

   logic            tx_clk  = 1'b0;
   logic            reset_n = 1'b0;
   logic            ready   = 1'b0;
   logic [1:0]      mode    = 2'd0;
   logic [DW-1:0]   tx_data;
   logic [BYTES-1:0] tx_charisk;
   logic            frame_start;
   logic [15:0]     frame_cnt;

   gtp_frame_gen_param #(
      .BYTES(BYTES), .ALIGN_WORDS(ALIGN_WORDS), .FRAME_WORDS(FRAME_WORDS)
   ) dut (
      .tx_clk(tx_clk), .reset_n(reset_n), .ready(ready), .mode(mode),
      .tx_data(tx_data), .tx_charisk(tx_charisk),
      .frame_start(frame_start), .frame_cnt(frame_cnt)
   );

   always #5 tx_clk = ~tx_clk;

   typedef struct {
      logic [DW-1:0]    data;
      logic [BYTES-1:0] k;
      logic             fs;
      logic [15:0]      fc;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   logic [7:0]  tab [0:5] = '{8'h54, 8'h58, 8'h34, 8'h40, 8'hA7, 8'h23};
   bit          prbs_bits [0:NBITS-1];

   // model: 0=off, 1=aligning, 2=in frame data, 3=just sent frame comma
   int          m_phase = 0;
   int          m_align = 0;
   int          m_w     = 0;
   int          m_mode  = 0;
   int          m_fcnt  = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, want);
      end
   endtask

   // Data word w of a frame: bytes w*BYTES .. w*BYTES+BYTES-1 of the frame's byte stream.
   function automatic logic [DW-1:0] frame_word(input int md, input int w);
      logic [DW-1:0] r;
      logic [7:0]    b;
      int            i;
      r = '0;
      for (int k = 0; k < BYTES; k++) begin
         i = w * BYTES + k;
         if (md == 1) b = 8'(i % 256);
         else if (md == 2) begin
            for (int j = 0; j < 8; j++) b[j] = prbs_bits[i*8 + j];
         end else b = tab[i % 6];
         r[8*k +: 8] = b;
      end
      return r;
   endfunction

   task automatic model_step(input logic rn, input logic rdy, input logic [1:0] md);
      exp_t e;
      e.data = '0; e.k = '0; e.fs = 1'b0;
      if (!rn) begin
         m_phase = 0; m_fcnt = 0;
      end else if (!rdy) begin
         m_phase = 0;
      end else if (m_phase == 0) begin
         m_phase = 1; m_align = 1;
         e.data = {BYTES{8'hBC}}; e.k = '1;
      end else if (m_phase == 1 && m_align < ALIGN_WORDS) begin
         m_align++;
         e.data = {BYTES{8'hBC}}; e.k = '1;
      end else if (m_phase == 1 || m_phase == 3) begin
         m_mode  = (md == 2'd3) ? 0 : int'(md);
         e.data  = frame_word(m_mode, 0);
         e.fs    = 1'b1;
         m_w     = 1;
         m_phase = 2;
      end else if (m_w == FRAME_WORDS) begin
         e.data  = {BYTES{8'hBC}}; e.k = '1;
         m_fcnt  = (m_fcnt + 1) % 65536;
         m_phase = 3;
      end else begin
         e.data = frame_word(m_mode, m_w);
         m_w++;
      end
      e.fc = 16'(m_fcnt);
      exp_q.push_back(e);
   endtask

   task automatic cycle(input logic rn, input logic rdy, input logic [1:0] md);
      @(negedge tx_clk);
      reset_n = rn; ready = rdy; mode = md;
      model_step(rn, rdy, md);
   endtask

   task automatic run(input int n, input logic rdy, input logic [1:0] md);
      for (int i = 0; i < n; i++) cycle(1'b1, rdy, md);
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge tx_clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("tx_data",     32'(tx_data),     32'(e.data));
            chk("tx_charisk",  32'(tx_charisk),  32'(e.k));
            chk("frame_start", 32'(frame_start), 32'(e.fs));
            chk("frame_cnt",   32'(frame_cnt),   32'(e.fc));
         end
      end
   end

   initial begin
      logic [6:0] s;
      bit         nb;
      logic [1:0] md;
      logic       rdy;
      int         rdy_low;

      s = 7'h7F;
      for (int n = 0; n < NBITS; n++) begin
         nb = s[6] ^ s[5];
         s  = {s[5:0], nb};
         prbs_bits[n] = nb;
      end

      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'd0);
      run(20, 1'b0, 2'd0);
      run(300, 1'b1, 2'd0);
      run(300, 1'b1, 2'd1);
      run(300, 1'b1, 2'd2);
      run(150, 1'b1, 2'd3);

      md = 2'd0; rdy_low = 0;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 39) == 0) md = 2'($urandom_range(0, 3));
         if (rdy_low == 0 && $urandom_range(0, 299) == 0) rdy_low = int'($urandom_range(1, 6));
         rdy = (rdy_low == 0);
         if (rdy_low > 0) rdy_low--;
         cycle(1'b1, rdy, md);
      end

      // ready drop in mid-frame, then restart with a fresh alignment burst
      run(40, 1'b1, 2'd0);
      run(5, 1'b0, 2'd0);
      run(100, 1'b1, 2'd0);

      // asynchronous reset in mid-DATA, checked between clock edges
      @(posedge tx_clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("async_rst tx_data",     32'(tx_data),     32'h0);
      chk("async_rst tx_charisk",  32'(tx_charisk),  32'h0);
      chk("async_rst frame_start", 32'(frame_start), 32'h0);
      chk("async_rst frame_cnt",   32'(frame_cnt),   32'h0);
      cycle(1'b0, 1'b1, 2'd1);
      cycle(1'b0, 1'b1, 2'd1);
      run(100, 1'b1, 2'd1);

      @(posedge tx_clk);
      #2;
      chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gtp_frame_gen_param.md
Name: gtp_frame_gen_param

Overview:
Parametrised transmit-side frame generator for GTP link bring-up and BER testing. It drives the transceiver TX parallel data and per-byte K-flags. After link ready, it emits a burst of K28.5 alignment words, then repeating frames. Each frame is a programmable number of data words in one of three modes (fixed 8b10b table, byte counter, PRBS7), followed by a K28.5 comma word. It replaces the fixed 16-bit generator in link benches and also ships in hardware as a link exerciser.

Parameters:
BYTES, 2, bytes per TX word (legal: 2 or 4)
ALIGN_WORDS, 16, comma words emitted after ready rises, before the first frame (>=1)
FRAME_WORDS, 6, data words per frame (>=1)

Ports:
tx_clk  in  1  TX user clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
ready  in  1  TX reset done; level, synchronous to tx_clk
mode  in  2  0=fixed table, 1=byte counter, 2=PRBS7, 3=reserved (treated as 0)
tx_data  out  8*BYTES  TX word; byte k occupies bits [8k+7:8k]; byte 0 is transmitted first
tx_charisk  out  BYTES  per-byte K flag; bit k qualifies byte k
frame_start  out  1  one-cycle pulse coincident with the first data word of each frame
frame_cnt  out  16  count of completed frames; wraps at 0xFFFF->0

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; tx_data=0, tx_charisk=0, frame_start=0, frame_cnt=0; word counter, table index, byte counter and PRBS register are cleared, with PRBS loaded to 7'h7F.
- All outputs are registered; one cycle of latency from state to outputs.
- States:
  - IDLE: outputs 0. When ready=1, go to ALIGN on the next edge.
  - ALIGN: emit ALIGN_WORDS comma words. A comma word has every byte = 8'hBC and tx_charisk = all ones. Then go to DATA.
  - DATA: emit FRAME_WORDS data words with tx_charisk = 0. Then go to COMMA.
  - COMMA: emit exactly one comma word. Increment frame_cnt on this word. Then go to DATA.
- ready=0 in any state: go to IDLE on the next edge and zero the outputs from that edge. frame_cnt holds its value; only reset_n clears it. When ready rises again, the generator restarts from ALIGN.
- mode is sampled once, on entry to DATA (the first data word of each frame). Changes mid-frame take effect at the next frame.
- On every DATA entry, the frame-local generators are reset:
  - table index = 0
  - byte counter = 0
  - PRBS = 7'h7F
- Mode 0, fixed table: a byte stream 8'h54, 8'h58, 8'h34, 8'h40, 8'hA7, 8'h23 (D20.2 D24.2 D20.1 D0.2 D7.5 D3.1), repeating. Bytes fill byte 0 upward, so each word consumes BYTES consecutive stream bytes. The index wraps modulo 6 and continues across words.
- Mode 1, byte counter: byte k of a word = (counter + k) mod 256. The counter advances by BYTES per word and wraps mod 256.
- Mode 2, PRBS7 (x^7+x^6+1):
  - Each step: new_bit = s[6]^s[5]; s = {s[5:0], new_bit}.
  - Each byte takes 8 successive new_bits, the first into bit 0.
  - Bytes are produced in order 0..BYTES-1, i.e. 8*BYTES steps per word, unrolled combinationally.
  - The state carries across words within a frame.
- frame_start is high on exactly the first DATA word of each frame; it is 0 in all other cycles.
- No data word ever equals a comma with charisk set. Data bytes may numerically equal 8'hBC (counter/PRBS); they carry charisk=0.

Test Plan:
- Reset/idle: hold reset_n=0, then release with ready=0 for 20 cycles -> tx_data=0, tx_charisk=0, frame_start=0, frame_cnt=0 throughout.
- Alignment + fixed table, BYTES=2, ALIGN_WORDS=4, FRAME_WORDS=6, mode=0: raise ready ->
  - 4 words of 16'hBCBC with charisk=2'b11;
  - then 16'h5854, 16'h4034, 16'h23A7, 16'h5854, 16'h4034, 16'h23A7 with charisk=0;
  - frame_start only on the first of these;
  - then 16'hBCBC with charisk 2'b11; frame_cnt=1 after it.
- Counter mode, BYTES=4, FRAME_WORDS=70, mode=1: first data word 32'h03020100, second 32'h07060504. Word 64 (index 0-based) returns to 32'h03020100, confirming the mod-256 wrap.
- PRBS mode, BYTES=2: first data word equals a reference PRBS7 model seeded 7'h7F. Over 127 words, every byte matches the model, the sequence restarts identically after the comma, and charisk stays 0.
- Mode change mid-frame: switch mode 0->1 at data word 3 -> the current frame completes in table mode; the next frame starts at 16'h0100.
- ready drop mid-frame, then asynchronous reset mid-DATA:
  - Drop ready during DATA -> outputs 0 from the next edge and frame_cnt held.
  - Re-raise ready -> a full ALIGN burst precedes the data, which restarts at 16'h5854.
  - Assert reset_n=0 mid-DATA -> outputs and frame_cnt clear immediately, without waiting for a clock edge.
